// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and types for the 2-read / 1-write integer register file.
package reg_file_2r1w_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [AW-1:0]   addr_t;
  typedef logic [XLEN-1:0] data_t;

  // Architectural zero register; never stored, never busy.
  localparam addr_t X0 = '0;

  // True when a strobe targets a real (non-x0) register at the given address.
  function automatic logic hits(input logic en, input addr_t strobe_addr, input addr_t addr);
    return en && (strobe_addr == addr) && (addr != X0);
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Read, writeback and issue signals between the pipeline and the register file.
interface reg_file_2r1w_if;
  import reg_file_2r1w_pkg::*;

  logic  rd_req;
  addr_t rs1_addr;
  addr_t rs2_addr;
  data_t rs1_data;
  data_t rs2_data;
  logic  rs1_busy;
  logic  rs2_busy;
  logic  rd_valid;
  logic  wr_en;
  addr_t wr_addr;
  data_t wr_data;
  logic  issue_en;
  addr_t issue_addr;

  // Pipeline side: decode issues reads/issue marks, writeback drives writes.
  modport master (
    output rd_req, rs1_addr, rs2_addr,
    output wr_en, wr_addr, wr_data,
    output issue_en, issue_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, rd_valid
  );

  // Register file side.
  modport slave (
    input  rd_req, rs1_addr, rs2_addr,
    input  wr_en, wr_addr, wr_data,
    input  issue_en, issue_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rd_valid
  );

endinterface

// File: rtl/reg_file_2r1w_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, set winning when both hit the same register.
module reg_file_2r1w_scoreboard
  import reg_file_2r1w_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  issue_en_i,
  input  addr_t issue_addr_i,
  input  logic  wr_en_i,
  input  addr_t wr_addr_i,
  input  addr_t rs1_addr_i,
  input  addr_t rs2_addr_i,
  output logic  rs1_busy_o,
  output logic  rs2_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: clear on writeback, then set on issue (set wins).
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (hits(wr_en_i, wr_addr_i, addr_t'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (hits(issue_en_i, issue_addr_i, addr_t'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read-out sees this cycle's clear but not this cycle's set, so a
  // forwarded write reports not-busy and a fresh issue shows up next read.
  always_comb begin
    rs1_busy_o = busy_q[rs1_addr_i] && !hits(wr_en_i, wr_addr_i, rs1_addr_i)
                 && (rs1_addr_i != X0);
    rs2_busy_o = busy_q[rs2_addr_i] && !hits(wr_en_i, wr_addr_i, rs2_addr_i)
                 && (rs2_addr_i != X0);
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32 x 32-bit integer register file: two registered read ports with
// write-first forwarding, one write port, and a pending-write scoreboard.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  reg_file_2r1w_if.slave bus
);

  data_t regs_q [NREGS];

  data_t rs1_data_d;
  data_t rs2_data_d;
  data_t rs1_data_q;
  data_t rs2_data_q;
  logic  rs1_busy_d;
  logic  rs2_busy_d;
  logic  rs1_busy_q;
  logic  rs2_busy_q;
  logic  rd_valid_q;

  reg_file_2r1w_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issue_en_i   (bus.issue_en),
    .issue_addr_i (bus.issue_addr),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .rs1_addr_i   (bus.rs1_addr),
    .rs2_addr_i   (bus.rs2_addr),
    .rs1_busy_o   (rs1_busy_d),
    .rs2_busy_o   (rs2_busy_d)
  );

  // Storage array; x0 is never written so it stays zero from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wr_en && (bus.wr_addr != X0)) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read muxes: x0 reads zero, a same-cycle write to the address forwards.
  always_comb begin
    rs1_data_d = regs_q[bus.rs1_addr];
    rs2_data_d = regs_q[bus.rs2_addr];
    if (bus.rs1_addr == X0) begin
      rs1_data_d = '0;
    end else if (hits(bus.wr_en, bus.wr_addr, bus.rs1_addr)) begin
      rs1_data_d = bus.wr_data;
    end
    if (bus.rs2_addr == X0) begin
      rs2_data_d = '0;
    end else if (hits(bus.wr_en, bus.wr_addr, bus.rs2_addr)) begin
      rs2_data_d = bus.wr_data;
    end
  end

  // Output registers: valid follows rd_req, data/busy hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_busy_q <= 1'b0;
      rs2_busy_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rs1_data_q <= rs1_data_d;
        rs2_data_q <= rs2_data_d;
        rs1_busy_q <= rs1_busy_d;
        rs2_busy_q <= rs2_busy_d;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rs1_data = rs1_data_q;
  assign bus.rs2_data = rs2_data_q;
  assign bus.rs1_busy = rs1_busy_q;
  assign bus.rs2_busy = rs2_busy_q;

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32 x 32-bit RISC-V integer register file built from the team's 32-bit enable-gated register cell.
- This block is the read side, the consumer of what the register cells store:
  - two registered read ports (rs1, rs2),
  - one write port (rd),
  - a per-register pending-write scoreboard.
- Sits between decode (read/issue) and writeback (write) in the core pipeline.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; x0 is hardwired zero
- AW, 5, register address width; must equal log2(NREGS)

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  read request; samples rs1_addr/rs2_addr this cycle
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data, valid when rd_valid=1
- rs2_data  out  XLEN  read port 2 data, valid when rd_valid=1
- rs1_busy  out  1  rs1 register had a pending write at sample time
- rs2_busy  out  1  rs2 register had a pending write at sample time
- rd_valid  out  1  read data/busy outputs valid (one cycle after rd_req)
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- issue_en  in  1  marks issue_addr as pending-write
- issue_addr  in  AW  destination of newly issued instruction

Behaviour:
- Reset (async, rst=1, immediate):
  - all registers cleared to 0, all busy bits cleared;
  - rs1_data=0, rs2_data=0, rs1_busy=0, rs2_busy=0, rd_valid=0.
  - Reset asserted mid-read: rd_valid drops immediately and no stale data appears after release.
- Write:
  - on rising edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data.
  - Writes to x0 are ignored.
- Read latency is 1 cycle.
  - rd_req=1 in cycle N gives rd_valid=1 in cycle N+1, with rs*_data/rs*_busy registered.
  - rd_req=0 gives rd_valid=0 the next cycle; data outputs hold their last value.
- x0: rs*_data=0 and rs*_busy=0 always, regardless of writes or issue.
- Write-read forwarding: if rd_req and wr_en are both high in the same cycle and rsX_addr==wr_addr!=0, then rsX_data in cycle N+1 = wr_data (new value, write-first).
  - Applies independently to each port; both ports may forward at once.
- Scoreboard, one busy bit per register:
  - issue_en=1 and issue_addr!=0: busy[issue_addr] <= 1.
  - wr_en=1 and wr_addr!=0: busy[wr_addr] <= 0.
  - Same address set and cleared in the same cycle: set wins. A new producer has been issued, so busy stays 1.
  - rsX_busy reflects busy after that cycle's clear but before that cycle's set. A write in the same cycle therefore reports not-busy (consistent with forwarding); an issue in the same cycle is not visible until the next read.
  - Repeated issue to an already-busy register keeps it 1. There is no counting and no error output.
  - A write to a non-busy register is legal and leaves busy=0.
- Arithmetic: none. Address compare is exact AW-bit equality. Out-of-range addresses are impossible because NREGS=2^AW.

Decomposition:
- Shared package: XLEN, NREGS, AW constants, and the X0 address constant (0).
- The natural sub-module is reg_scoreboard (busy vector with set/clear priority and read-out logic).
- The storage array and forwarding muxes stay in the top.

Test Plan:
- Reset value: assert rst mid-run with regs[5]=0x1234_5678. Read rs1=5, rs2=0 → rd_valid=1 next cycle, rs1_data=0, rs2_data=0, rs1_busy=0.
- Basic write/read: write x7=0xDEAD_BEEF, then rd_req with rs1=7, rs2=7 → both data=0xDEAD_BEEF exactly one cycle later.
- x0 immutable: wr_en with wr_addr=0, data 0xFFFF_FFFF, plus issue_addr=0 → a read of rs1=0 gives 0 and busy=0.
- Forwarding: regs[3]=0x11. In the same cycle, wr x3=0x22 and rd_req rs1=3, rs2=4 → rs1_data=0x22, rs2_data=old x4, rs1_busy=0.
- Scoreboard: issue x9, read rs1=9 → busy=1. Same cycle issue x9 and wr x9 → stays busy. Wr x9 alone → the next read shows busy=0 with data=written value.
- Async reset mid-operation: rd_req high and rst pulsed between edges → outputs zero immediately. With rst released and rd_req=0, rd_valid stays 0.
